// File: rtl/cache_controller.sv
// Direct-mapped cache controller: CPU word accesses over a 4-line x 4-word cache,
// with dirty-line write-back and block fill from a 128-bit memory port.
module cache_controller (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic         cpu_ready,
    output logic [31:0]  cpu_rdata,
    output logic         write_word,
    output logic         write_block,
    output logic         comp,
    output logic [1:0]   index,
    output logic [1:0]   word,
    output logic [25:0]  tag_out,
    output logic [31:0]  word_out,
    output logic [127:0] block_out,
    input  logic         hit,
    input  logic         dirty,
    input  logic         valid,
    input  logic [31:0]  data_out,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);

    typedef enum logic [2:0] {IDLE, COMPARE, WB_READ, WB_MEM, FILL} state_t;

    state_t      state, state_next;
    logic        lat_we;
    logic [31:2] lat_addr;
    logic [31:0] lat_wdata;
    logic        first_pass;
    logic [1:0]  wb_cnt;
    logic [31:0] wb_buf [4];
    logic [25:0] shadow_tag [4];

    logic [25:0] lat_tag;
    logic [1:0]  lat_index;
    logic [1:0]  lat_word;
    logic        accept;
    logic        addr_lsb_unused;

    assign lat_tag         = lat_addr[31:6];
    assign lat_index       = lat_addr[5:4];
    assign lat_word        = lat_addr[3:2];
    assign addr_lsb_unused = ^cpu_addr[1:0];

    // A completion pulse blocks acceptance so a held request is not taken twice.
    assign accept = (state == IDLE) && cpu_req && !cpu_ready;

    always_comb begin
        state_next  = state;
        write_word  = 1'b0;
        write_block = 1'b0;
        comp        = 1'b0;
        index       = lat_index;
        word        = lat_word;
        tag_out     = lat_tag;
        word_out    = lat_wdata;
        block_out   = mem_rdata;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {lat_tag, lat_index, 4'b0000};
        mem_wdata   = {wb_buf[3], wb_buf[2], wb_buf[1], wb_buf[0]};
        case (state)
            IDLE: begin
                if (accept) state_next = COMPARE;
            end
            COMPARE: begin
                comp = 1'b1;
                if (hit) begin
                    write_word = lat_we;
                    state_next = IDLE;
                end else if (valid && dirty) begin
                    state_next = WB_READ;
                end else begin
                    state_next = FILL;
                end
            end
            WB_READ: begin
                word = wb_cnt;
                if (wb_cnt == 2'd3) state_next = WB_MEM;
            end
            WB_MEM: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {shadow_tag[lat_index], lat_index, 4'b0000};
                if (mem_ready) state_next = FILL;
            end
            FILL: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    write_block = 1'b1;
                    state_next  = COMPARE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A reset edge abandons the transaction, so no cache write may escape in that cycle.
        if (reset) begin
            write_word  = 1'b0;
            write_block = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            first_pass <= 1'b0;
            wb_cnt     <= '0;
            for (int i = 0; i < 4; i++) begin
                wb_buf[i]     <= '0;
                shadow_tag[i] <= '0;
            end
        end else begin
            state     <= state_next;
            cpu_ready <= 1'b0;
            if (accept) begin
                lat_we     <= cpu_we;
                lat_addr   <= cpu_addr[31:2];
                lat_wdata  <= cpu_wdata;
                first_pass <= 1'b1;
            end
            // Only the first lookup of a request is counted; the re-compare after a fill is not.
            if (state == COMPARE) begin
                first_pass <= 1'b0;
                if (hit) begin
                    cpu_ready <= 1'b1;
                    if (!lat_we) cpu_rdata <= data_out;
                    if (first_pass && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                end else if (first_pass && miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
            if (state == WB_READ) begin
                wb_buf[wb_cnt] <= data_out;
                wb_cnt         <= wb_cnt + 2'd1;
            end else begin
                wb_cnt <= '0;
            end
            if (write_block) shadow_tag[lat_index] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache array and a
// latency-programmable memory responder.
module tb_cache_controller;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         write_word, write_block, comp;
    logic [1:0]   index, word;
    logic [25:0]  tag_out;
    logic [31:0]  word_out;
    logic [127:0] block_out;
    logic         hit, dirty, valid;
    logic [31:0]  data_out;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [15:0]  hit_count, miss_count;

    cache_controller dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .write_word(write_word), .write_block(write_block), .comp(comp),
        .index(index), .word(word), .tag_out(tag_out), .word_out(word_out), .block_out(block_out),
        .hit(hit), .dirty(dirty), .valid(valid), .data_out(data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    // Behavioural cache: combinational lookup, writes at the clock edge.
    logic        cache_clear = 1'b1;
    logic [31:0] c_data [4][4];
    logic [25:0] c_tag [4];
    logic        c_valid [4];
    logic        c_dirty [4];

    always_comb begin
        hit      = comp && c_valid[index] && (c_tag[index] == tag_out);
        valid    = c_valid[index];
        dirty    = c_dirty[index];
        data_out = c_data[index][word];
    end

    always @(posedge clock) begin
        if (cache_clear) begin
            for (int i = 0; i < 4; i++) begin
                c_valid[i] <= 1'b0;
                c_dirty[i] <= 1'b0;
                c_tag[i]   <= '0;
                for (int j = 0; j < 4; j++) c_data[i][j] <= '0;
            end
        end else begin
            if (write_word) begin
                c_data[index][word] <= word_out;
                c_dirty[index]      <= 1'b1;
            end
            if (write_block) begin
                for (int n = 0; n < 4; n++) c_data[index][n] <= block_out[32*n +: 32];
                c_tag[index]   <= tag_out;
                c_valid[index] <= 1'b1;
                c_dirty[index] <= 1'b0;
            end
        end
    end

    // Memory image: address 0x40 holds a recognisable block, others word n = addr + n.
    function automatic logic [127:0] fill_image(input logic [31:0] a);
        if (a == 32'h0000_0040) return {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        return {a + 32'd3, a + 32'd2, a + 32'd1, a};
    endfunction

    int           mem_delay = 2;
    int           mem_wait = 0;
    logic [31:0]  wr_addr_log = '0;
    logic [127:0] wr_data_log = '0;

    always @(posedge clock) begin
        #1;
        mem_ready = 1'b0;
        if (mem_req) begin
            if (mem_wait >= mem_delay) begin
                mem_ready = 1'b1;
                mem_wait  = 0;
                if (mem_we) begin
                    wr_addr_log = mem_addr;
                    wr_data_log = mem_wdata;
                end else begin
                    mem_rdata = fill_image(mem_addr);
                end
            end else begin
                mem_wait++;
            end
        end else begin
            mem_wait = 0;
        end
    end

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    int          r_cycles, r_wb_cycles, r_wblock, r_wword, r_both, r_fill_cycles;
    logic        r_timeout, r_fill_gap, r_fill_unstable;
    logic [31:0] r_rdata, r_fill_addr;

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int budget, input logic hold);
        logic seen_comp, seen_mem, got_fill, done;
        seen_comp = 0; seen_mem = 0; got_fill = 0; done = 0;
        r_cycles = 0; r_wb_cycles = 0; r_wblock = 0; r_wword = 0; r_both = 0; r_fill_cycles = 0;
        r_fill_gap = 0; r_fill_unstable = 0; r_rdata = '0; r_fill_addr = '0;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        while (!done && r_cycles < budget) begin
            @(negedge clock);
            r_cycles++;
            if (write_block) r_wblock++;
            if (write_word) r_wword++;
            if (write_word && write_block) r_both++;
            if (cpu_ready) begin
                done    = 1;
                r_rdata = cpu_rdata;
            end else begin
                if (comp) seen_comp = 1;
                if (mem_req) begin
                    seen_mem = 1;
                    if (!mem_we) begin
                        if (!got_fill) begin
                            got_fill    = 1;
                            r_fill_addr = mem_addr;
                        end else if (mem_addr != r_fill_addr) begin
                            r_fill_unstable = 1;
                        end
                        r_fill_cycles++;
                    end
                end else begin
                    if (got_fill && r_wblock == 0) r_fill_gap = 1;
                    if (seen_comp && !seen_mem && !comp) r_wb_cycles++;
                end
            end
        end
        r_timeout = !done;
        if (!hold) cpu_req = 1'b0;
    endtask

    initial begin
        logic found;
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;
        logic [31:0] held_addr;

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("rst_cpu_ready", cpu_ready, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_comp", comp, 0);
        checkOutput("rst_write_word", write_word, 0);
        checkOutput("rst_write_block", write_block, 0);
        checkOutput("rst_hit_count", hit_count, 0);
        checkOutput("rst_miss_count", miss_count, 0);
        reset = 1'b0;
        cache_clear = 1'b0;

        // Cold read miss of 0x40
        $display("[TB] cold read 0x40");
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 50, 1'b0);
        checkOutput("cold_timeout", r_timeout, 0);
        checkOutput("cold_fill_addr", r_fill_addr, 32'h0000_0040);
        checkOutput("cold_wblock", r_wblock, 1);
        checkOutput("cold_wb_cycles", r_wb_cycles, 0);
        checkOutput("cold_rdata", r_rdata, 32'hDEAD_BEEF);
        checkOutput("cold_latency", r_cycles, 6);
        checkOutput("cold_miss_count", miss_count, 1);
        checkOutput("cold_hit_count", hit_count, 0);

        // Write hit then read-back of 0x44
        $display("[TB] write hit / read hit 0x44");
        applyStimulus(1'b1, 32'h0000_0044, 32'h1234_5678, 50, 1'b0);
        checkOutput("wr_wword", r_wword, 1);
        checkOutput("wr_wblock", r_wblock, 0);
        checkOutput("wr_latency", r_cycles, 2);
        checkOutput("wr_hit_count", hit_count, 1);
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 50, 1'b0);
        checkOutput("rd_rdata", r_rdata, 32'h1234_5678);
        checkOutput("rd_latency", r_cycles, 2);
        checkOutput("rd_hit_count", hit_count, 2);
        checkOutput("rd_miss_count", miss_count, 1);

        // Dirty eviction of line 0 (tag 1) by 0x1000_0000
        $display("[TB] dirty eviction");
        applyStimulus(1'b0, 32'h1000_0000, 32'h0, 80, 1'b0);
        checkOutput("ev_timeout", r_timeout, 0);
        checkOutput("ev_wb_cycles", r_wb_cycles, 4);
        checkOutput("ev_wb_addr", wr_addr_log, 32'h0000_0040);
        checkOutput("ev_wb_data", wr_data_log,
                    {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hDEAD_BEEF});
        checkOutput("ev_fill_addr", r_fill_addr, 32'h1000_0000);
        checkOutput("ev_rdata", r_rdata, 32'h1000_0000);
        checkOutput("ev_latency", r_cycles, 13);
        checkOutput("ev_miss_count", miss_count, 2);
        checkOutput("ev_hit_count", hit_count, 2);
        checkOutput("ev_both_writes", r_both, 0);

        // Slow fill: memory withholds ready for 20 cycles
        $display("[TB] slow fill 0x20");
        mem_delay = 20;
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 80, 1'b0);
        checkOutput("slow_fill_cycles", r_fill_cycles, 21);
        checkOutput("slow_fill_gap", r_fill_gap, 0);
        checkOutput("slow_fill_unstable", r_fill_unstable, 0);
        checkOutput("slow_fill_addr", r_fill_addr, 32'h0000_0020);
        checkOutput("slow_wblock", r_wblock, 1);
        checkOutput("slow_latency", r_cycles, 24);
        checkOutput("slow_rdata", r_rdata, 32'h0000_0020);
        checkOutput("slow_miss_count", miss_count, 3);
        mem_delay = 2;

        // Request held across the completion pulse
        $display("[TB] held request");
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 50, 1'b1);
        checkOutput("hold_first_latency", r_cycles, 2);
        @(negedge clock);
        checkOutput("hold_no_reaccept_comp", comp, 0);
        checkOutput("hold_no_reaccept_ready", cpu_ready, 0);
        @(negedge clock);
        checkOutput("hold_second_comp", comp, 1);
        @(negedge clock);
        checkOutput("hold_second_ready", cpu_ready, 1);
        checkOutput("hold_second_rdata", cpu_rdata, 32'h0000_0020);
        cpu_req = 1'b0;
        checkOutput("hold_hit_count", hit_count, 4);

        // Reset in the middle of a write-back
        $display("[TB] reset during write-back");
        applyStimulus(1'b1, 32'h1000_0004, 32'hCAFE_F00D, 50, 1'b0);
        checkOutput("rwb_setup_wword", r_wword, 1);
        checkOutput("rwb_setup_hits", hit_count, 5);
        mem_delay = 1000;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0080;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clock);
            if (mem_req && mem_we) found = 1;
        end
        checkOutput("rwb_reached_wb_mem", found, 1);
        cpu_req = 1'b0;
        held_addr = mem_addr;
        checkOutput("rwb_wb_addr", held_addr, 32'h1000_0000);
        repeat (3) @(negedge clock);
        checkOutput("rwb_req_held", mem_req, 1);
        checkOutput("rwb_addr_stable", mem_addr, held_addr);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rwb_mem_req", mem_req, 0);
        checkOutput("rwb_comp", comp, 0);
        checkOutput("rwb_write_block", write_block, 0);
        checkOutput("rwb_cpu_ready", cpu_ready, 0);
        checkOutput("rwb_hit_count", hit_count, 0);
        checkOutput("rwb_miss_count", miss_count, 0);
        reset = 1'b0;
        mem_delay = 2;
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, 50, 1'b0);
        checkOutput("post_rst_fill_addr", r_fill_addr, 32'h0000_0030);
        checkOutput("post_rst_rdata", r_rdata, 32'h0000_0030);
        checkOutput("post_rst_latency", r_cycles, 6);
        checkOutput("post_rst_miss_count", miss_count, 1);
        checkOutput("post_rst_hit_count", hit_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
